// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store access controller.
// Runs one req/ack data-memory transaction per pipeline access. It stalls the
// front end while the access is in flight. Extended load data is returned
// with a one-cycle valid pulse.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword/word accesses are trapped and the misalign output pulses. When it is
// undefined, the offending low address bits are ignored.
module lsu_mem_ctrl #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mreq,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    // The counter holds the number of REQ cycles already spent without an ack.
    // Aborting when it reaches ACK_TIMEOUT-1 gives exactly ACK_TIMEOUT REQ cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic        we_reg;
    logic [2:0]  f3_reg;
    logic [1:0]  addr_lo_reg;
    logic [7:0]  cnt_reg;
    logic        ld_valid_reg;
    logic [31:0] ld_data_reg;
    logic        bus_err_reg;
    logic        bus_req_reg;
    logic        bus_we_reg;
    logic [31:0] bus_addr_reg;
    logic [31:0] bus_wdata_reg;
    logic [3:0]  bus_be_reg;

    // Access size decode for the request being accepted in IDLE.
    // Any funct3 whose low bits are not 00/01 is treated as a word access.
    logic        acc_byte;
    logic        acc_half;
    logic [31:0] wdata_next;
    logic [3:0]  be_next;
    logic        trap_hit;

    assign acc_byte = (funct3[1:0] == 2'b00);
    assign acc_half = (funct3[1:0] == 2'b01);

    // Per-lane store data replication and byte enables.
    // Halfword lanes key off addr[1] only, so a halfword at offset 3 acts as
    // offset 2, and a word ignores both low address bits.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_next[8*gi +: 8] = acc_byte ? wdata[7:0] :
                                           acc_half ? wdata[8*(gi%2) +: 8] :
                                                      wdata[8*gi +: 8];
            assign be_next[gi] = acc_byte ? (addr[1:0] == 2'(gi)) :
                                 acc_half ? (addr[1] == 1'(gi/2)) :
                                            1'b1;
        end
    endgenerate

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_reg;

    // A misaligned halfword or word never reaches the bus.
    assign trap_hit = (acc_half & addr[0]) |
                      (~acc_byte & ~acc_half & (addr[1:0] != 2'b00));
    assign misalign = misalign_reg;
`else
    assign trap_hit = 1'b0;
`endif

    // Load lane selection and extension, using the offset and funct3 latched at accept.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_byte = bus_rdata[{addr_lo_reg, 3'b000} +: 8];
        ld_half = bus_rdata[{addr_lo_reg[1], 4'b0000} +: 16];
        case (f3_reg)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h000000, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0000, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    // Stall covers the accepting IDLE cycle and every REQ cycle. It drops in DONE,
    // so the pipeline advances at the end of DONE. Reset forces it low.
    assign stall = rst_n & (((state_reg == ST_IDLE) & mreq) | (state_reg == ST_REQ));

    assign ld_valid  = ld_valid_reg;
    assign ld_data   = ld_data_reg;
    assign bus_err   = bus_err_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_be    = bus_be_reg;

    // Access FSM: it accepts in IDLE and holds the bus in REQ until ack or
    // timeout. It reports the result in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            we_reg        <= 1'b0;
            f3_reg        <= 3'b000;
            addr_lo_reg   <= 2'b00;
            cnt_reg       <= 8'd0;
            ld_valid_reg  <= 1'b0;
            ld_data_reg   <= 32'h0;
            bus_err_reg   <= 1'b0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 32'h0;
            bus_wdata_reg <= 32'h0;
            bus_be_reg    <= 4'b0000;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_reg  <= 1'b0;
`endif
        end else begin
            ld_valid_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_reg <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (mreq && trap_hit) begin
                        state_reg    <= ST_DONE;
`ifdef LSU_MISALIGN_TRAP_EN
                        misalign_reg <= 1'b1;
`endif
                    end else if (mreq) begin
                        we_reg        <= mem_write;
                        f3_reg        <= funct3;
                        addr_lo_reg   <= addr[1:0];
                        cnt_reg       <= 8'd0;
                        bus_req_reg   <= 1'b1;
                        bus_we_reg    <= mem_write;
                        bus_addr_reg  <= {addr[31:2], 2'b00};
                        bus_wdata_reg <= wdata_next;
                        bus_be_reg    <= be_next;
                        state_reg     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (bus_ack) begin
                        bus_req_reg <= 1'b0;
                        bus_we_reg  <= 1'b0;
                        if (!we_reg) begin
                            ld_data_reg  <= ld_ext;
                            ld_valid_reg <= 1'b1;
                        end
                        state_reg <= ST_DONE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        bus_req_reg <= 1'b0;
                        bus_we_reg  <= 1'b0;
                        bus_err_reg <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl (ACK_TIMEOUT = 8).
// It adapts its misalignment expectations to LSU_MISALIGN_TRAP_EN.
module tb_lsu_mem_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mreq;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ACK_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mreq      (mreq),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign  (misalign)
`endif
    );

    // Runs one access for ncyc cycles. It starts 1 time unit after a rising
    // edge, with the DUT in IDLE. Ack is given in REQ cycle waits+1; waits < 0
    // means ack is never given. It records what was seen at each falling edge.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int waits, input logic [31:0] rd,
                             input int ncyc,
                             output int stall_cyc, output int req_cyc, output int valid_cyc,
                             output int valid_at, output int err_cyc, output int mis_cyc,
                             output logic [31:0] s_addr, output logic [31:0] s_wdata,
                             output logic [3:0] s_be, output logic s_we,
                             output logic [31:0] s_ld);
        bit seen = 0;
        stall_cyc = 0; req_cyc = 0; valid_cyc = 0; valid_at = 0; err_cyc = 0; mis_cyc = 0;
        s_addr = '0; s_wdata = '0; s_be = '0; s_we = 1'b0; s_ld = '0;
        mreq = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (stall) stall_cyc++;
            if (bus_req) begin
                req_cyc++;
                if (!seen) begin
                    seen = 1;
                    s_addr = bus_addr; s_wdata = bus_wdata; s_be = bus_be; s_we = bus_we;
                end
                if (waits >= 0 && req_cyc == waits + 1) begin
                    bus_ack = 1'b1;
                    bus_rdata = rd;
                end
            end
            if (ld_valid) begin
                valid_cyc++;
                valid_at = c;
                s_ld = ld_data;
            end
            if (bus_err) err_cyc++;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misalign) mis_cyc++;
`endif
            @(posedge clk); #1;
            mreq = 1'b0;
            bus_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mreq = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        #3;
        checks++;
        if ({stall, ld_valid, bus_err, bus_req, bus_we, bus_be} !== 9'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000000", {stall, ld_valid, bus_err, bus_req, bus_we, bus_be});
        end
        checks++;
        if (ld_data !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got ld=%h addr=%h wd=%h exp=0", ld_data, bus_addr, bus_wdata);
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_lw();
        int sc, rc, vc, va, ec, mc;
        logic [31:0] sa, sw, ld;
        logic [3:0] be;
        logic we;
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 6,
                  sc, rc, vc, va, ec, mc, sa, sw, be, we, ld);
        checks++;
        if (sa !== 32'h100 || be !== 4'b1111 || we !== 1'b0) begin
            failures++;
            $display("FAIL lw_bus got addr=%h be=%b we=%b exp addr=00000100 be=1111 we=0", sa, be, we);
        end
        checks++;
        if (sc !== 2 || rc !== 1) begin
            failures++;
            $display("FAIL lw_stall got stall=%0d req=%0d exp stall=2 req=1", sc, rc);
        end
        checks++;
        if (vc !== 1 || va !== 3 || ld !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lw_load got valid=%0d at=%0d data=%h exp valid=1 at=3 data=deadbeef", vc, va, ld);
        end
        $display("test_lw addr=00000100 ld_data=%h stall_cycles=%0d", ld, sc);
    endtask

    task automatic test_lb_lbu();
        int sc, rc, vc, va, ec, mc;
        logic [31:0] sa, sw, ld;
        logic [3:0] be;
        logic we;
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80123456, 5,
                  sc, rc, vc, va, ec, mc, sa, sw, be, we, ld);
        checks++;
        if (ld !== 32'hFFFFFF80 || vc !== 1 || be !== 4'b1000) begin
            failures++;
            $display("FAIL lb_sign got data=%h valid=%0d be=%b exp data=ffffff80 valid=1 be=1000", ld, vc, be);
        end
        $display("test_lb addr=00000103 ld_data=%h", ld);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80123456, 5,
                  sc, rc, vc, va, ec, mc, sa, sw, be, we, ld);
        checks++;
        if (ld !== 32'h00000080 || vc !== 1) begin
            failures++;
            $display("FAIL lbu_zero got data=%h valid=%0d exp data=00000080 valid=1", ld, vc);
        end
        $display("test_lbu addr=00000103 ld_data=%h", ld);
    endtask

    task automatic test_back_to_back();
        // First access: lh at 0x102. mreq stays high through REQ and DONE.
        mreq = 1'b1; mem_write = 1'b0; funct3 = 3'b001; addr = 32'h102; wdata = '0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept_stall got=%b exp=1", stall);
        end
        @(posedge clk); #1;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h80017FFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        funct3 = 3'b101; addr = 32'h100;
        @(negedge clk);
        checks++;
        if (ld_valid !== 1'b1 || ld_data !== 32'hFFFF8001 || stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_lh got valid=%b data=%h stall=%b exp valid=1 data=ffff8001 stall=0", ld_valid, ld_data, stall);
        end
        $display("test_back_to_back lh addr=00000102 ld_data=%h", ld_data);
        // Next cycle is IDLE, and the pending lhu is accepted.
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_accept got stall=%b req=%b exp stall=1 req=0", stall, bus_req);
        end
        @(posedge clk); #1;
        mreq = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_be !== 4'b0011) begin
            failures++;
            $display("FAIL b2b_lhu_bus got req=%b addr=%h be=%b exp req=1 addr=00000100 be=0011", bus_req, bus_addr, bus_be);
        end
        bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (ld_valid !== 1'b1 || ld_data !== 32'h00007FFF) begin
            failures++;
            $display("FAIL b2b_lhu got valid=%b data=%h exp valid=1 data=00007fff", ld_valid, ld_data);
        end
        $display("test_back_to_back lhu addr=00000100 ld_data=%h", ld_data);
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        int sc, rc, vc, va, ec, mc;
        logic [31:0] sa, sw, ld;
        logic [3:0] be;
        logic we;
        do_access(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 4, 32'h0, 9,
                  sc, rc, vc, va, ec, mc, sa, sw, be, we, ld);
        checks++;
        if (we !== 1'b1 || be !== 4'b1100 || sw !== 32'hABCDABCD || sa !== 32'h200) begin
            failures++;
            $display("FAIL sh_bus got we=%b be=%b wd=%h addr=%h exp we=1 be=1100 wd=abcdabcd addr=00000200", we, be, sw, sa);
        end
        checks++;
        if (sc !== 6 || rc !== 5 || vc !== 0) begin
            failures++;
            $display("FAIL sh_timing got stall=%0d req=%0d valid=%0d exp stall=6 req=5 valid=0", sc, rc, vc);
        end
        $display("test_sh addr=00000202 be=%b wdata=%h stall_cycles=%0d", be, sw, sc);
        do_access(1'b1, 3'b000, 32'h101, 32'h12345677, 0, 32'h0, 5,
                  sc, rc, vc, va, ec, mc, sa, sw, be, we, ld);
        checks++;
        if (be !== 4'b0010 || sw !== 32'h77777777 || vc !== 0) begin
            failures++;
            $display("FAIL sb_bus got be=%b wd=%h valid=%0d exp be=0010 wd=77777777 valid=0", be, sw, vc);
        end
        $display("test_sb addr=00000101 be=%b wdata=%h", be, sw);
        do_access(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 1, 32'h0, 6,
                  sc, rc, vc, va, ec, mc, sa, sw, be, we, ld);
        checks++;
        if (be !== 4'b1111 || sw !== 32'hCAFEF00D || sa !== 32'h300) begin
            failures++;
            $display("FAIL sw_bus got be=%b wd=%h addr=%h exp be=1111 wd=cafef00d addr=00000300", be, sw, sa);
        end
        $display("test_sw addr=00000300 be=%b wdata=%h", be, sw);
    endtask

    task automatic test_timeout();
        int sc, rc, vc, va, ec, mc;
        logic [31:0] sa, sw, ld;
        logic [3:0] be;
        logic we;
        do_access(1'b0, 3'b010, 32'h400, 32'h0, -1, 32'h0, 12,
                  sc, rc, vc, va, ec, mc, sa, sw, be, we, ld);
        checks++;
        if (rc !== TO || ec !== 1 || vc !== 0) begin
            failures++;
            $display("FAIL timeout got req=%0d err=%0d valid=%0d exp req=8 err=1 valid=0", rc, ec, vc);
        end
        checks++;
        if (sc !== TO + 1 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_stall got stall=%0d req_now=%b exp stall=9 req_now=0", sc, bus_req);
        end
        $display("test_timeout req_cycles=%0d err_pulses=%0d", rc, ec);
    endtask

    task automatic test_misalign();
        int sc, rc, vc, va, ec, mc;
        logic [31:0] sa, sw, ld;
        logic [3:0] be;
        logic we;
        do_access(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h01020304, 5,
                  sc, rc, vc, va, ec, mc, sa, sw, be, we, ld);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (mc !== 1 || rc !== 0 || sc !== 1 || vc !== 0) begin
            failures++;
            $display("FAIL lw_misalign_trap got mis=%0d req=%0d stall=%0d valid=%0d exp 1 0 1 0", mc, rc, sc, vc);
        end
`else
        checks++;
        if (sa !== 32'h100 || be !== 4'b1111 || ld !== 32'h01020304 || vc !== 1) begin
            failures++;
            $display("FAIL lw_misalign_pass got addr=%h be=%b data=%h valid=%0d exp addr=00000100 be=1111 data=01020304 valid=1", sa, be, ld, vc);
        end
`endif
        $display("test_misalign lw addr=00000101 req_cycles=%0d stall_cycles=%0d", rc, sc);
        do_access(1'b0, 3'b001, 32'h103, 32'h0, 0, 32'hFEDC0123, 5,
                  sc, rc, vc, va, ec, mc, sa, sw, be, we, ld);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (mc !== 1 || rc !== 0 || vc !== 0) begin
            failures++;
            $display("FAIL lh_misalign_trap got mis=%0d req=%0d valid=%0d exp 1 0 0", mc, rc, vc);
        end
`else
        checks++;
        if (be !== 4'b1100 || ld !== 32'hFFFFFEDC || vc !== 1) begin
            failures++;
            $display("FAIL lh_misalign_pass got be=%b data=%h valid=%0d exp be=1100 data=fffffedc valid=1", be, ld, vc);
        end
`endif
        $display("test_misalign lh addr=00000103 req_cycles=%0d", rc);
    endtask

    task automatic test_reset_mid_req();
        int sc, rc, vc, va, ec, mc, bad;
        logic [31:0] sa, sw, ld;
        logic [3:0] be;
        logic we;
        mreq = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(posedge clk); #1;
        mreq = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL midreq_setup got req=%b exp=1", bus_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || ld_data !== 32'h0) begin
            failures++;
            $display("FAIL midreq_reset got req=%b stall=%b ld=%h exp req=0 stall=0 ld=0", bus_req, stall, ld_data);
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ld_valid || bus_err || bus_req) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL midreq_discard got active_cycles=%0d exp=0", bad);
        end
        @(posedge clk); #1;
        do_access(1'b0, 3'b010, 32'h104, 32'h0, 0, 32'h13579BDF, 5,
                  sc, rc, vc, va, ec, mc, sa, sw, be, we, ld);
        checks++;
        if (ld !== 32'h13579BDF || vc !== 1 || sa !== 32'h104) begin
            failures++;
            $display("FAIL after_reset_lw got data=%h valid=%0d addr=%h exp data=13579bdf valid=1 addr=00000104", ld, vc, sa);
        end
        $display("test_reset_mid_req next lw ld_data=%h", ld);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_back_to_back();
        test_store();
        test_timeout();
        test_misalign();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog in case the stimulus stops making progress.
    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
